// File: rtl/keccak_padder_param.sv
// ============================================================================
// keccak_padder_param: packs W-bit words into RATE-bit Keccak blocks with padding
// Revision: 1.0
// ============================================================================
`default_nettype none

module keccak_padder_param #(
  parameter int W        = 32,
  parameter int RATE     = 576,
  parameter int PAD_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [W-1:0]               in,
  input  logic                       in_ready,
  input  logic                       is_last,
  input  logic [$clog2(W/8)-1:0]     byte_num,
  input  logic                       f_ack,
  output logic                       buffer_full,
  output logic [RATE-1:0]            out,
  output logic                       out_ready,
  output logic                       last_block
);

  localparam int NB   = W / 8;
  localparam int NW   = RATE / W;
  localparam int BN_W = $clog2(W / 8);
  localparam int CW   = $clog2(NW + 1);
  localparam logic [7:0] PAD_BYTE = (PAD_MODE == 1) ? 8'h06 : 8'h01;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    FULL   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RATE-1:0] out_q, out_d;
  logic            out_ready_q, out_ready_d;
  logic            last_block_q, last_block_d;

  logic [W-1:0]    last_word;
  logic [W-1:0]    word;
  logic            shift;
  logic            word_pad;
  logic            fin;

  // Final word: keep the leading byte_num bytes, drop in the pad byte, zero the rest
  for (genvar g = 0; g < NB; g++) begin : g_last_bytes
    assign last_word[W-1-8*g -: 8] =
        (byte_num > BN_W'(g))  ? in[W-1-8*g -: 8] :
        (byte_num == BN_W'(g)) ? PAD_BYTE : 8'h00;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    out_ready_d  = out_ready_q;
    last_block_d = last_block_q;
    word         = '0;
    shift        = 1'b0;
    word_pad     = 1'b0;
    fin          = (cnt_q == CW'(NW - 1));

    case (state_q)
      ACCEPT: begin
        if (in_ready) begin
          shift    = 1'b1;
          word_pad = is_last;
          word     = is_last ? last_word : in;
        end
      end
      PAD: begin
        shift    = 1'b1;
        word_pad = 1'b1;
      end
      FULL: begin
        if (f_ack) begin
          cnt_d        = '0;
          out_ready_d  = 1'b0;
          last_block_d = 1'b0;
          state_d      = last_block_q ? DONE : ACCEPT;
        end
      end
      default: ;
    endcase

    if (shift) begin
      // Only a block carrying the pad byte can complete from here with word_pad set
      if (fin && word_pad) begin
        word[7:0] = word[7:0] | 8'h80;
      end
      out_d = {out_q[RATE-W-1:0], word};
      cnt_d = cnt_q + CW'(1);
      if (fin) begin
        state_d      = FULL;
        out_ready_d  = 1'b1;
        last_block_d = word_pad;
      end else if (word_pad) begin
        state_d = PAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCEPT;
      cnt_q        <= '0;
      out_q        <= '0;
      out_ready_q  <= 1'b0;
      last_block_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_ready_q  <= out_ready_d;
      last_block_q <= last_block_d;
    end
  end

  assign buffer_full = (state_q != ACCEPT);
  assign out         = out_q;
  assign out_ready   = out_ready_q;
  assign last_block  = last_block_q;

endmodule

`default_nettype wire
